// File: rtl/ram_burst_pkg.sv
// Shared constants, FSM state type and address helper for the RAM burst controller.
package ram_burst_pkg;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Address arithmetic wraps naturally at the RAM size.
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction
endpackage

// File: rtl/burst_rd_fifo.sv
// Two-entry read-data buffer; each entry carries a byte plus the last-beat tag.
module burst_rd_fifo
   import ram_burst_pkg::*;
#(
   parameter int W = DATA_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [0:1];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop   = i_pop && (r_count != 2'd0);
   assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

   // Storage, pointers and occupancy; reset flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a 64x8 single-port RAM with a registered read address.
// Write bursts stream straight into the RAM; read bursts are credit-limited into a 2-entry buffer.
module ram_burst_ctrl
   import ram_burst_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              done,
   output logic              ram_write_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);
   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-1:0]   r_beats;
   logic               r_inflight;
   logic               r_inflight_last;
   logic               r_done;
   logic [1:0]         w_fifo_count;
   logic [DATA_W:0]    w_fifo_head;
   logic               w_head_last;
   logic               w_pop;
   logic [2:0]         w_credit;
   logic               w_issue;
   logic               w_wbeat;
   logic               w_accept;
   logic               w_last_beat;

   assign rd_valid    = (w_fifo_count != 2'd0);
   assign w_head_last = w_fifo_head[DATA_W];
   assign rd_data     = w_fifo_head[DATA_W-1:0];
   assign rd_last     = rd_valid & w_head_last;
   assign w_pop       = rd_valid & rd_ready;
   assign w_last_beat = (r_beats == {LEN_W{1'b0}});
   assign w_accept    = (r_state == IDLE) && req_valid;
   assign w_wbeat     = (r_state == WRITE) && wr_valid;

   // Buffered entries plus the read still in the RAM pipe must leave room for one more.
   assign w_credit = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue  = (r_state == READ) && (w_credit < 3'd2);

   assign req_ready   = (r_state == IDLE);
   assign wr_ready    = (r_state == WRITE);
   assign ram_address = r_addr;
   assign done        = r_done;

   // RAM write strobe and write data, gated to the WRITE state.
   always_comb begin
      ram_write_en = 1'b0;
      ram_data_in  = {DATA_W{1'b0}};
      if (r_state == WRITE) begin
         ram_write_en = wr_valid;
         ram_data_in  = wr_data;
      end else begin
         ram_write_en = 1'b0;
         ram_data_in  = {DATA_W{1'b0}};
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = req_write ? WRITE : READ;
            end else begin
               w_next = IDLE;
            end
         end
         WRITE: begin
            if (w_wbeat && w_last_beat) begin
               w_next = IDLE;
            end else begin
               w_next = WRITE;
            end
         end
         READ: begin
            if (w_issue && w_last_beat) begin
               w_next = DRAIN;
            end else begin
               w_next = READ;
            end
         end
         DRAIN: begin
            if (w_pop && w_head_last) begin
               w_next = IDLE;
            end else begin
               w_next = DRAIN;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Address and remaining-beat counters, advanced once per write or issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= {ADDR_W{1'b0}};
         r_beats <= {LEN_W{1'b0}};
      end else if (w_accept) begin
         r_addr  <= req_addr;
         r_beats <= req_len;
      end else if (w_wbeat || w_issue) begin
         r_addr  <= addr_inc(r_addr);
         r_beats <= r_beats - {{(LEN_W-1){1'b0}}, 1'b1};
      end else begin
         r_addr  <= r_addr;
         r_beats <= r_beats;
      end
   end

   // Read pipe tracking and the completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && w_last_beat;
         r_done          <= (w_wbeat && w_last_beat) ||
                            ((r_state == DRAIN) && w_pop && w_head_last);
      end
   end

   burst_rd_fifo #(.W(DATA_W + 1)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_data  ({r_inflight_last, ram_data_out}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_head),
      .o_count (w_fifo_count)
   );
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: RAM model, transaction-level reference model and directed + random bursts.
module tb_ram_burst_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [5:0] req_addr = 6'd0, req_len = 6'd0;
   logic       wr_valid = 1'b0, wr_ready;
   logic [7:0] wr_data = 8'd0;
   logic       rd_valid, rd_ready = 1'b1, rd_last, done;
   logic [7:0] rd_data;
   logic       ram_write_en;
   logic [5:0] ram_address;
   logic [7:0] ram_data_in, ram_data_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   ram_burst_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .ram_write_en(ram_write_en), .ram_address(ram_address),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: synchronous write, registered read address, plus a preload port.
   logic [7:0] mem [0:63];
   logic [5:0] ram_raddr_q;
   logic       pl_en = 1'b0;
   logic [5:0] pl_addr = 6'd0;
   logic [7:0] pl_data = 8'd0;
   always @(posedge clk) begin
      if (ram_write_en) mem[ram_address] <= ram_data_in;
      else if (pl_en) mem[pl_addr] <= pl_data;
      ram_raddr_q <= ram_address;
   end
   assign ram_data_out = mem[ram_raddr_q];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: what the burst must look like at the transaction level.
   logic [7:0] shadow [0:63];
   bit         m_busy = 1'b0;
   int         m_mode = 0;
   logic [5:0] m_addr = 6'd0;
   int         m_left = 0;
   bit         m_done_due = 1'b0;
   logic [5:0] wlog_addr[$];
   int         wlog_cyc[$];
   logic [7:0] rlog_data[$];
   bit         rlog_last[$];
   int         rlog_cyc[$];
   int         acc_cyc[$];
   int         done_cyc[$];

   always @(negedge clk) begin
      bit was_idle;
      if (pl_en) shadow[pl_addr] = pl_data;
      if (!rst_n) begin
         m_busy = 1'b0; m_mode = 0; m_done_due = 1'b0;
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_done", done, 0);
         chk("rst_ram_we", ram_write_en, 0);
         chk("rst_wr_ready", wr_ready, 0);
      end else begin
         was_idle = !m_busy;
         chk("req_ready", req_ready, was_idle);
         chk("wr_ready", wr_ready, m_mode == 1);
         chk("done", done, m_done_due);
         if (done) done_cyc.push_back(cyc);
         m_done_due = 1'b0;
         chk("ram_we", ram_write_en, (m_mode == 1) && wr_valid);
         if (m_mode != 1) chk("ram_din_idle", ram_data_in, 0);
         if (m_mode != 2) chk("rd_valid_idle", rd_valid, 0);
         if (m_mode == 1 && wr_valid) begin
            chk("wr_addr", ram_address, m_addr);
            chk("wr_din", ram_data_in, wr_data);
            shadow[m_addr] = wr_data;
            wlog_addr.push_back(m_addr);
            wlog_cyc.push_back(cyc);
            m_addr = m_addr + 6'd1;
            if (m_left == 0) begin
               m_mode = 0; m_busy = 1'b0; m_done_due = 1'b1;
            end else m_left--;
         end else if (m_mode == 2 && rd_valid && rd_ready) begin
            chk("rd_data", rd_data, shadow[m_addr]);
            chk("rd_last", rd_last, m_left == 0);
            rlog_data.push_back(rd_data);
            rlog_last.push_back(rd_last);
            rlog_cyc.push_back(cyc);
            m_addr = m_addr + 6'd1;
            if (m_left == 0) begin
               m_mode = 0; m_busy = 1'b0; m_done_due = 1'b1;
            end else m_left--;
         end
         if (was_idle && req_valid) begin
            acc_cyc.push_back(cyc);
            m_busy = 1'b1;
            m_mode = req_write ? 1 : 2;
            m_addr = req_addr;
            m_left = int'(req_len);
         end
      end
   end

   task automatic send_req(input logic w, input logic [5:0] a, input logic [5:0] l);
      bit acc = 1'b0;
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
      while (!acc && n < 100) begin
         @(negedge clk); acc = req_ready;
         @(posedge clk); #1; n++;
      end
      req_valid = 1'b0;
      chk("req_accept", acc, 1);
   endtask

   // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random. hold: wr_valid held with base+k data.
   task automatic run_until_done(input int rmode, input bit hold, input logic [7:0] base);
      bit d = 1'b0, hs;
      int k = 0, n = 0;
      while (!d && n < 600) begin
         wr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
         wr_data  = hold ? base + 8'(k) : 8'($urandom);
         case (rmode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (n % 3 == 0);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk); d = done; hs = wr_valid && wr_ready;
         @(posedge clk); #1; n++;
         if (hs) k++;
      end
      wr_valid = 1'b0; rd_ready = 1'b1;
      chk("burst_done_seen", d, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ws, rs, as, dc, k;
      bit hs;
      for (int i = 0; i < 64; i++) begin
         pl_en = 1'b1; pl_addr = 6'(i); pl_data = 8'(i * 7 + 3);
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_addr", ram_address, 0);

      // Write burst across the wrap point.
      ws = wlog_addr.size(); dc = done_cyc.size();
      send_req(1'b1, 6'h3E, 6'd3);
      run_until_done(0, 1'b1, 8'hA0);
      chk("wrap_wr_count", wlog_addr.size() - ws, 4);
      chk("wrap_a0", wlog_addr[ws], 8'h3E);
      chk("wrap_a1", wlog_addr[ws+1], 8'h3F);
      chk("wrap_a2", wlog_addr[ws+2], 8'h00);
      chk("wrap_a3", wlog_addr[ws+3], 8'h01);
      chk("wrap_back2back", wlog_cyc[ws+3] - wlog_cyc[ws], 3);
      chk("wrap_done_lat", done_cyc[dc], wlog_cyc[ws+3] + 1);
      chk("wrap_mem", mem[0], 8'hA2);

      // Read it back at full rate.
      rs = rlog_data.size(); as = acc_cyc.size(); dc = done_cyc.size();
      send_req(1'b0, 6'h3E, 6'd3);
      run_until_done(0, 1'b0, 8'h00);
      chk("rb_count", rlog_data.size() - rs, 4);
      for (int i = 0; i < 4; i++) begin
         chk("rb_data", rlog_data[rs+i], 8'hA0 + 8'(i));
         chk("rb_last", rlog_last[rs+i], i == 3);
      end
      chk("rb_first_lat", rlog_cyc[rs] - acc_cyc[as], 3);
      chk("rb_back2back", rlog_cyc[rs+3] - rlog_cyc[rs], 3);
      chk("rb_done_lat", done_cyc[dc], rlog_cyc[rs+3] + 1);

      // Backpressured 8-beat read.
      rs = rlog_data.size();
      send_req(1'b0, 6'h10, 6'd7);
      run_until_done(1, 1'b0, 8'h00);
      chk("bp_count", rlog_data.size() - rs, 8);
      chk("bp_first", rlog_data[rs], 8'h73);
      chk("bp_last_data", rlog_data[rs+7], 8'hA4);

      // Single-beat and full-length reads.
      rs = rlog_data.size();
      send_req(1'b0, 6'h05, 6'd0);
      run_until_done(0, 1'b0, 8'h00);
      chk("len0_count", rlog_data.size() - rs, 1);
      chk("len0_data", rlog_data[rs], 8'h26);
      chk("len0_last", rlog_last[rs], 1);
      rs = rlog_data.size();
      send_req(1'b0, 6'h00, 6'd63);
      run_until_done(2, 1'b0, 8'h00);
      chk("len63_count", rlog_data.size() - rs, 64);
      chk("len63_first", rlog_data[rs], 8'hA2);
      chk("len63_lastdata", rlog_data[rs+63], 8'hA1);
      chk("len63_lastflag", rlog_last[rs+63], 1);
      chk("len63_addr_wrap", ram_address, 0);

      // Reset after two of six write beats.
      send_req(1'b1, 6'h00, 6'd5);
      k = 0;
      for (int n = 0; n < 50 && k < 2; n++) begin
         wr_valid = 1'b1; wr_data = 8'h50 + 8'(k);
         @(negedge clk); hs = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (hs) k++;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_we_drop", ram_write_en, 0);
      chk("rst_wr_ready_drop", wr_ready, 0);
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem0", mem[0], 8'h50);
      chk("rst_mem1", mem[1], 8'h51);
      chk("rst_mem2", mem[2], 8'h11);
      chk("rst_mem3", mem[3], 8'h18);
      chk("rst_mem4", mem[4], 8'h1F);
      chk("rst_mem5", mem[5], 8'h26);

      // Request held during a read burst: next one accepted in the done cycle.
      dc = done_cyc.size();
      send_req(1'b0, 6'h20, 6'd3);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h08; req_len = 6'd1;
      run_until_done(0, 1'b0, 8'h00);
      req_valid = 1'b0;
      chk("lockout_accept_cycle", acc_cyc[$], done_cyc[dc]);
      run_until_done(0, 1'b0, 8'h00);

      // Random bursts.
      for (int b = 0; b < 40; b++) begin
         logic w;
         logic [5:0] a, l;
         w = 1'($urandom_range(0, 1));
         a = 6'($urandom);
         l = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 10));
         send_req(w, a, l);
         run_until_done(2, 1'b0, 8'h00);
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller sitting directly upstream of the 64-byte single-port RAM (8-bit × 64, write-enable, registered read address). Accepts one burst request at a time (write or read, start address, length 1–64) over valid/ready handshakes and drives the RAM's write_en, address and data_in ports. On reads, it captures RAM data_out into a 2-entry buffer and presents it as a backpressured stream with a last-beat marker. Addresses wrap modulo 64.

## Interface
- ADDR_W, 6, RAM address width (64 locations)
- DATA_W, 8, RAM data width (1 byte)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  6  beats minus one (0 → 1 beat, 63 → 64 beats)
- wr_valid  in  1  write data valid
- wr_ready  out  1  high only in WRITE
- wr_data  in  DATA_W  write byte
- rd_valid  out  1  read data valid
- rd_ready  in  1  read data consumer ready
- rd_data  out  DATA_W  read byte
- rd_last  out  1  high with the final read beat of the burst
- done  out  1  one-cycle pulse when the burst completes
- ram_write_en  out  1  to RAM write_en
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM data_in
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: req_ready=1. On req_valid: load addr counter ← req_addr, beat counter ← req_len. Go to WRITE (req_write=1) or READ.
- ram_address = addr counter in all states. Counter increments mod 64 (0x3F → 0x00) on each write or issue.
- WRITE: wr_ready=1. ram_write_en = wr_valid (combinational), ram_data_in = wr_data. Each accepted beat writes, then increments address and decrements beat count. After the beat with count 0, go to IDLE and pulse done on the next cycle.
- READ: ram_write_en=0. An issue takes place in a cycle when (fifo_count + inflight − pop) < 2, with pop = rd_valid & rd_ready and inflight = "issued last cycle". The RAM captures ram_address at that edge. ram_data_out is valid in the following cycle and is pushed into the FIFO at the end of that cycle. After the last issue, go to DRAIN.
- DRAIN: no issues. When the last beat pops (rd_valid & rd_ready & rd_last), go to IDLE and pulse done.
- rd_last is carried as a FIFO tag, set on the entry from the final issue.
- ram_write_en is never high outside WRITE. ram_data_in is 0 outside WRITE.
- Asynchronous reset, or reset mid-burst, aborts the burst:
  - state IDLE, counters 0, FIFO flushed
  - rd_valid, rd_last, done, ram_write_en, wr_ready = 0; req_ready = 1 after release
  - no done pulse for the aborted burst

## Timing
- Write: request accepted in cycle N → wr_ready high from N+1. Each beat writes RAM in the same cycle as its wr handshake. Zero bubbles when wr_valid is held high. done is high one cycle after the last write.
- Read: request accepted in cycle N → first issue in N+1 → first rd_valid in N+3. Sustains 1 beat/cycle while rd_ready=1.
- Backpressure: with rd_ready=0, at most 2 beats are buffered. Issue stalls and no data is lost or duplicated.
- done is high in the cycle after the last read pop; req_ready is high in that same cycle.
- Requests are never accepted while busy (req_ready=0).

## Structure
- Package ram_burst_pkg: ADDR_W/DATA_W constants, LEN_W=6, state enum {IDLE, WRITE, READ, DRAIN}.
- Sub-module burst_rd_fifo: 2-entry synchronous FIFO, DATA_W+1 wide (data plus last tag), with count output and flush on reset.
- Top holds the FSM, address/beat counters and the credit logic.
- Bench: pair with the existing RAM block as the memory model.

## Test plan
- Write wrap: req_write=1, addr 0x3E, len 3, data A0..A3 with wr_valid held → RAM writes 0x3E,0x3F,0x00,0x01 on consecutive cycles; done one cycle after the last write.
- Read back the same burst, rd_ready=1 → rd_data A0,A1,A2,A3 starting 3 cycles after accept, on consecutive cycles; rd_last only on A3; done follows.
- Backpressure: 8-beat read from 0x10, rd_ready toggling 1,0,0,1… → all 8 bytes in order, no duplicates, FIFO never exceeds 2 entries.
- Boundary lengths: len 0 at 0x05 → single beat with rd_last=1. len 63 at 0x00 → 64 beats, address wraps back to 0x00.
- Reset mid-burst: assert rst_n=0 after 2 of 6 write beats → ram_write_en drops immediately, no done. After release, req_ready=1 and addresses 0x02+ are unwritten.
- Busy lockout: hold req_valid during a read burst → req_ready=0 until the done cycle, then the next request is accepted.
